// File: rtl/fp64_mul_scheduler_if.sv
// Requester and response bundle for the shared FP64 multiplier.
// The scheduler sits on the slave side; the issue logic drives the master side.
interface fp64_mul_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_data;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/fp64_mul_scheduler.sv
// Round-robin sharing of one FP64 multiplier among NREQ requesters,
// with in-order, ID-tagged results returned through a small FIFO.
module fp64_mul_scheduler #(
    parameter int NREQ = 4,
    parameter int PIPE = 2,
    parameter int IDW  = 2
) (
    input logic                clk,
    input logic                rst,
    fp64_mul_scheduler_if.slave bus
);
    localparam int DEPTH = PIPE + 3;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [CW-1:0]  DMAX  = CW'(DEPTH);
    localparam logic [PW-1:0]  PLAST = PW'(DEPTH - 1);
    localparam logic [IDW:0]   NR    = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] ILAST = IDW'(NREQ - 1);

    logic [IDW-1:0]  rr_ptr, gid;
    logic [IDW:0]    scan;
    logic            found, can_issue, accept, pop;
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   outstanding;
    logic [63:0]     opa, opb;

    assign can_issue = outstanding < DMAX;
    assign accept    = found && can_issue;

    always_comb begin
        gid   = '0;
        found = 1'b0;
        scan  = '0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (scan >= NR) scan = scan - NR;
            if (!found && bus.req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                gid   = scan[IDW-1:0];
            end
        end
        if (can_issue && found) grant[gid] = 1'b1;
    end

    assign bus.req_ready = grant;
    assign opa = bus.req_a[{gid, 6'd0} +: 64];
    assign opb = bus.req_b[{gid, 6'd0} +: 64];

    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (accept) rr_ptr <= (gid == ILAST) ? '0 : gid + IDW'(1);
    end

    logic           s0_valid, s0_zero;
    logic [63:0]    s0_a, s0_b, mul_res;
    logic [IDW-1:0] s0_id;

    always_ff @(posedge clk) begin
        if (rst) s0_valid <= 1'b0;
        else     s0_valid <= accept;
        if (accept) begin
            s0_a    <= opa;
            s0_b    <= opb;
            s0_id   <= gid;
            s0_zero <= (opa[62:0] == 63'd0) || (opb[62:0] == 63'd0);
        end
    end

    // Normal operands round to nearest-even; subnormals flush to zero.
    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        logic               s, g, st, ainf, binf, anan, bnan, az, bz;
        logic [10:0]        ea, eb;
        logic [105:0]       p;
        logic [52:0]        m;
        logic signed [12:0] e;
        s    = a[63] ^ b[63];
        ea   = a[62:52];
        eb   = b[62:52];
        anan = (&ea) && (|a[51:0]);
        bnan = (&eb) && (|b[51:0]);
        ainf = (&ea) && !(|a[51:0]);
        binf = (&eb) && !(|b[51:0]);
        az   = ea == 11'd0;
        bz   = eb == 11'd0;
        p    = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
        if (p[105]) begin
            m  = {1'b0, p[104:53]};
            g  = p[52];
            st = |p[51:0];
            e  = e + 13'sd1;
        end else begin
            m  = {1'b0, p[103:52]};
            g  = p[51];
            st = |p[50:0];
        end
        m = m + 53'(g & (st | m[0]));
        if (m[52]) e = e + 13'sd1;
        if (anan || bnan || (ainf && bz) || (binf && az))
            return 64'h7FF8_0000_0000_0000;
        if (ainf || binf || e >= 13'sd2047) return {s, 11'h7FF, 52'd0};
        if (az || bz || e <= 13'sd0) return {s, 63'd0};
        return {s, e[10:0], m[51:0]};
    endfunction

    assign mul_res = s0_zero ? {s0_a[63] ^ s0_b[63], 63'd0} : fmul(s0_a, s0_b);

    logic           wr_valid;
    logic [IDW-1:0] wr_id;
    logic [63:0]    wr_data;

    if (PIPE == 0) begin : g_direct
        assign wr_valid = s0_valid;
        assign wr_id    = s0_id;
        assign wr_data  = mul_res;
    end else begin : g_pipe
        logic           pv  [PIPE];
        logic [IDW-1:0] pid [PIPE];
        logic [63:0]    pd  [PIPE];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < PIPE; i++) pv[i] <= 1'b0;
            end else begin
                pv[0] <= s0_valid;
                for (int i = 1; i < PIPE; i++) pv[i] <= pv[i-1];
            end
            pid[0] <= s0_id;
            pd[0]  <= mul_res;
            for (int i = 1; i < PIPE; i++) begin
                pid[i] <= pid[i-1];
                pd[i]  <= pd[i-1];
            end
        end
        assign wr_valid = pv[PIPE-1];
        assign wr_id    = pid[PIPE-1];
        assign wr_data  = pd[PIPE-1];
    end

    logic [63:0]    fd [DEPTH];
    logic [IDW-1:0] fi [DEPTH];
    logic [PW-1:0]  wp, rp;
    logic [CW-1:0]  cnt;

    assign bus.rsp_valid = cnt != '0;
    assign bus.rsp_id    = fi[rp];
    assign bus.rsp_data  = fd[rp];
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.busy      = outstanding != '0;

    // Outstanding counts pipeline plus FIFO, so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            outstanding <= '0;
        end else begin
            if (wr_valid) begin
                fd[wp] <= wr_data;
                fi[wp] <= wr_id;
                wp     <= (wp == PLAST) ? '0 : wp + PW'(1);
            end
            if (pop) rp <= (rp == PLAST) ? '0 : rp + PW'(1);
            cnt         <= cnt + CW'(wr_valid) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fp64_mul_scheduler.sv
// Directed bench for fp64_mul_scheduler: arbitration order, latency,
// backpressure, zero override, mid-flight reset and fairness.
module tb_fp64_mul_scheduler;
    localparam int NREQ = 4;
    localparam int PIPE = 2;
    localparam int IDW  = 2;

    localparam logic [63:0] D0_5 = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] D1_0 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D1_5 = 64'h3FF8_0000_0000_0000;
    localparam logic [63:0] D2_0 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D3_0 = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D4_0 = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D6_0 = 64'h4018_0000_0000_0000;
    localparam logic [63:0] D8_0 = 64'h4020_0000_0000_0000;
    localparam logic [63:0] M2_0 = 64'hC000_0000_0000_0000;
    localparam logic [63:0] M3_0 = 64'hC008_0000_0000_0000;
    localparam logic [63:0] PZ   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] NZ   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] D2_25 = 64'h4002_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;
    logic [IDW-1:0] qid  [$];
    logic [63:0]    qdat [$];

    fp64_mul_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fp64_mul_scheduler #(.NREQ(NREQ), .PIPE(PIPE), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
        bus.req_a[64*i +: 64] = a;
        bus.req_b[64*i +: 64] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
        qid.delete();
        qdat.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        nvec++;
        if (bus.rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid);
        end
        nvec++;
        if (bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        nvec++;
        if (bus.req_ready !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_op(2, D2_0, D3_0);
        bus.req_valid = 4'b0100;
        #1;
        nvec++;
        if (bus.req_ready !== 4'b0100) begin
            nerr++;
            $display("FAIL single_grant got=%b want=0100", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            nvec++;
            if (bus.rsp_valid !== (k == 4)) begin
                nerr++;
                $display("FAIL single_latency cycle=%0d rsp_valid got=%b want=%b",
                         k, bus.rsp_valid, (k == 4));
            end
            if (k == 4) begin
                nvec++;
                if (bus.rsp_id !== 2'd2 || bus.rsp_data !== D6_0) begin
                    nerr++;
                    $display("FAIL single_rsp got id=%0d data=%h want id=2 data=%h",
                             bus.rsp_id, bus.rsp_data, D6_0);
                end
                nvec++;
                if (bus.busy !== 1'b1) begin
                    nerr++;
                    $display("FAIL single_busy got=%b want=1", bus.busy);
                end
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        nvec++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL single_drained got valid=%b busy=%b want 0 0",
                     bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]     ex [NREQ];
        logic [NREQ-1:0] eg;
        int first, last, got;
        do_reset();
        set_op(0, D1_0, D2_0); ex[0] = D2_0;
        set_op(1, D2_0, D2_0); ex[1] = D4_0;
        set_op(2, D3_0, D2_0); ex[2] = D6_0;
        set_op(3, D4_0, D2_0); ex[3] = D8_0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        first = -1;
        last  = -1;
        got   = 0;
        for (int c = 0; c < 40 && got < 12; c++) begin
            if (c == 12) bus.req_valid = '0;
            #1;
            if (c < 12) begin
                eg = '0;
                eg[c % NREQ] = 1'b1;
                nvec++;
                if (bus.req_ready !== eg) begin
                    nerr++;
                    $display("FAIL b2b_grant cycle=%0d got=%b want=%b", c, bus.req_ready, eg);
                end
                qid.push_back(IDW'(c % NREQ));
                qdat.push_back(ex[c % NREQ]);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                nvec++;
                if (qid.size() == 0) begin
                    nerr++;
                    $display("FAIL b2b_spurious got id=%0d data=%h want none",
                             bus.rsp_id, bus.rsp_data);
                end else begin
                    if (bus.rsp_id !== qid[0] || bus.rsp_data !== qdat[0]) begin
                        nerr++;
                        $display("FAIL b2b_rsp got id=%0d data=%h want id=%0d data=%h",
                                 bus.rsp_id, bus.rsp_data, qid[0], qdat[0]);
                    end
                    void'(qid.pop_front());
                    void'(qdat.pop_front());
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        nvec++;
        if (got != 12) begin
            nerr++;
            $display("FAIL b2b_count got=%0d want=12", got);
        end
        nvec++;
        if (first != 4 || last - first != 11) begin
            nerr++;
            $display("FAIL b2b_gapless got first=%0d span=%0d want first=4 span=11",
                     first, last - first);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]     ex [NREQ];
        logic [NREQ-1:0] eg;
        do_reset();
        set_op(0, D1_0, D2_0); ex[0] = D2_0;
        set_op(1, D2_0, D2_0); ex[1] = D4_0;
        set_op(2, D3_0, D2_0); ex[2] = D6_0;
        set_op(3, D4_0, D2_0); ex[3] = D8_0;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            eg = '0;
            if (c < 5) eg[c % NREQ] = 1'b1;
            nvec++;
            if (bus.req_ready !== eg) begin
                nerr++;
                $display("FAIL bp_grant cycle=%0d got=%b want=%b", c, bus.req_ready, eg);
            end
            if (c < 5) begin
                qid.push_back(IDW'(c % NREQ));
                qdat.push_back(ex[c % NREQ]);
            end
            tick();
        end
        nvec++;
        if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            nerr++;
            $display("FAIL bp_hold got busy=%b valid=%b want 1 1", bus.busy, bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && qid.size() != 0; c++) begin
            if (c == 2) bus.req_valid = '0;
            #1;
            if (c < 2) begin
                eg = (c == 0) ? 4'b0000 : 4'b0010;
                nvec++;
                if (bus.req_ready !== eg) begin
                    nerr++;
                    $display("FAIL bp_resume cycle=%0d got=%b want=%b", c, bus.req_ready, eg);
                end
                if (c == 1) begin
                    qid.push_back(IDW'(1));
                    qdat.push_back(ex[1]);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                nvec++;
                if (qid.size() == 0) begin
                    nerr++;
                    $display("FAIL bp_spurious got id=%0d want none", bus.rsp_id);
                end else begin
                    if (bus.rsp_id !== qid[0] || bus.rsp_data !== qdat[0]) begin
                        nerr++;
                        $display("FAIL bp_rsp got id=%0d data=%h want id=%0d data=%h",
                                 bus.rsp_id, bus.rsp_data, qid[0], qdat[0]);
                    end
                    void'(qid.pop_front());
                    void'(qdat.pop_front());
                end
            end
            tick();
        end
        nvec++;
        if (qid.size() != 0) begin
            nerr++;
            $display("FAIL bp_drain got %0d left want 0", qid.size());
        end
    endtask

    task automatic test_zero();
        logic [63:0]     ex [NREQ];
        logic [NREQ-1:0] eg, nxt;
        do_reset();
        set_op(0, NZ,   D3_0); ex[0] = NZ;
        set_op(1, D1_5, D1_5); ex[1] = D2_25;
        set_op(2, M2_0, PZ);   ex[2] = NZ;
        set_op(3, M2_0, D1_5); ex[3] = M3_0;
        bus.rsp_ready = 1'b1;
        nxt = '1;
        for (int c = 0; c < 30 && (c < 4 || qid.size() != 0); c++) begin
            bus.req_valid = nxt;
            #1;
            if (c < 4) begin
                eg = '0;
                eg[c] = 1'b1;
                nvec++;
                if (bus.req_ready !== eg) begin
                    nerr++;
                    $display("FAIL zero_grant cycle=%0d got=%b want=%b", c, bus.req_ready, eg);
                end
                qid.push_back(IDW'(c));
                qdat.push_back(ex[c]);
                nxt = nxt & ~eg;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                nvec++;
                if (qid.size() == 0) begin
                    nerr++;
                    $display("FAIL zero_spurious got id=%0d want none", bus.rsp_id);
                end else begin
                    if (bus.rsp_id !== qid[0] || bus.rsp_data !== qdat[0]) begin
                        nerr++;
                        $display("FAIL zero_rsp got id=%0d data=%h want id=%0d data=%h",
                                 bus.rsp_id, bus.rsp_data, qid[0], qdat[0]);
                    end
                    void'(qid.pop_front());
                    void'(qdat.pop_front());
                end
            end
            tick();
        end
        nvec++;
        if (qid.size() != 0) begin
            nerr++;
            $display("FAIL zero_drain got %0d left want 0", qid.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_valid = '1;
        tick();
        tick();
        tick();
        bus.req_valid = '0;
        #1;
        nvec++;
        if (bus.busy !== 1'b1) begin
            nerr++;
            $display("FAIL rmid_busy_before got=%b want=1", bus.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        nvec++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL rmid_cleared got valid=%b busy=%b want 0 0",
                     bus.rsp_valid, bus.busy);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            nvec++;
            if (bus.rsp_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rmid_ghost cycle=%0d got valid=%b want 0", c, bus.rsp_valid);
            end
            tick();
        end
        bus.req_valid = '1;
        #1;
        nvec++;
        if (bus.req_ready !== 4'b0001) begin
            nerr++;
            $display("FAIL rmid_grant got=%b want=0001", bus.req_ready);
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] eg;
        do_reset();
        set_op(0, D1_0, D1_0);
        set_op(3, D4_0, D0_5);
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && (c < 8 || qid.size() != 0); c++) begin
            if (c == 8) bus.req_valid = '0;
            #1;
            if (c < 8) begin
                eg = (c % 2 == 0) ? 4'b0001 : 4'b1000;
                nvec++;
                if (bus.req_ready !== eg) begin
                    nerr++;
                    $display("FAIL fair_grant cycle=%0d got=%b want=%b", c, bus.req_ready, eg);
                end
                qid.push_back((c % 2 == 0) ? 2'd0 : 2'd3);
                qdat.push_back((c % 2 == 0) ? D1_0 : D2_0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                nvec++;
                if (qid.size() == 0) begin
                    nerr++;
                    $display("FAIL fair_spurious got id=%0d want none", bus.rsp_id);
                end else begin
                    if (bus.rsp_id !== qid[0] || bus.rsp_data !== qdat[0]) begin
                        nerr++;
                        $display("FAIL fair_rsp got id=%0d data=%h want id=%0d data=%h",
                                 bus.rsp_id, bus.rsp_data, qid[0], qdat[0]);
                    end
                    void'(qid.pop_front());
                    void'(qdat.pop_front());
                end
            end
            tick();
        end
        nvec++;
        if (qid.size() != 0) begin
            nerr++;
            $display("FAIL fair_drain got %0d left want 0", qid.size());
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
